// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the IF/MEM memory bus arbiter:
//   - RESET_ENABLE / STALL_ENABLE feature switches
//   - default bus width constants
//   - 3-bit FSM state encodings
// Optional feature macro used by the arbiter: MEM_BUS_ARBITER_TIMEOUT_EN
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  // Reset clears outputs and forces the stall requests low while asserted.
  localparam bit RESET_ENABLE = 1'b1;
  // Stall requests toward the pipeline stall controller are generated.
  localparam bit STALL_ENABLE = 1'b1;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_SEL_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_IF_BUSY  = 3'd1,
    ST_MEM_BUSY = 3'd2,
    ST_IF_DONE  = 3'd3,
    ST_MEM_DONE = 3'd4
  } arb_state_e;

endpackage : mem_bus_arbiter_pkg

// File: rtl/mem_bus_timeout_counter.sv
// ---------------------------------------------------------------------------
// mem_bus_timeout_counter
// Counts consecutive BUSY cycles of the arbiter and flags the cycle in which
// the transaction has been outstanding for TIMEOUT_CYCLES cycles.
// Only instantiated when MEM_BUS_ARBITER_TIMEOUT_EN is defined.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous active-high reset
//   busy    in  arbiter is in IF_BUSY or MEM_BUSY
//   timeout out this BUSY cycle is the TIMEOUT_CYCLES-th one
// ---------------------------------------------------------------------------
module mem_bus_timeout_counter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  output logic timeout
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // cnt_q holds the number of BUSY cycles already elapsed before the current
  // one, so the current cycle is the TIMEOUT_CYCLES-th when cnt_q == LAST.
  // Outside BUSY the counter sits at zero, which gives the clear on entry.
  always_comb begin
    cnt_d = '0;
    if (busy) begin
      cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = busy & (cnt_q == CNT_LAST);

endmodule : mem_bus_timeout_counter

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one single-ported memory bus between the IF (fetch) and MEM (data)
// ports of the 5-stage pipeline. MEM has fixed priority over IF. Each access
// is a registered request/ack transaction: IDLE -> xx_BUSY -> xx_DONE -> IDLE,
// so back-to-back accesses are at least 3 cycles apart.
// Optional feature: define MEM_BUS_ARBITER_TIMEOUT_EN to abort a transaction
// after TIMEOUT_CYCLES BUSY cycles without ack (ready + bus_err, rdata = 0).
// Ports:
//   clk, reset                    clock, async active-high reset
//   if_req/if_addr                fetch request (held until if_ready)
//   if_rdata/if_ready             fetched word, one-cycle completion pulse
//   mem_req/we/sel/addr/wdata     data request (held until mem_ready)
//   mem_rdata/mem_ready           load data, one-cycle completion pulse
//   bus_req/we/sel/addr/wdata     registered bus master outputs
//   bus_rdata/bus_ack             slave read data and completion
//   bus_err                       abort flag, pulses with ready
//   stall_req_if/stall_req_mem    stall requests to the stall controller
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = BUS_ADDR_W,
  parameter int unsigned DATA_WIDTH     = BUS_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [BUS_SEL_W-1:0]  mem_sel,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [BUS_SEL_W-1:0]  bus_sel,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ack,
  output logic                  bus_err,
  output logic                  stall_req_if,
  output logic                  stall_req_mem
);

  // The timeout counter compares against TIMEOUT_CYCLES-1, which needs >= 2.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  arb_state_e            state_q, state_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [BUS_SEL_W-1:0]  bus_sel_q, bus_sel_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  if_ready_q, if_ready_d;
  logic                  mem_ready_q, mem_ready_d;
  logic                  timeout_hit;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  logic bus_err_q, bus_err_d;

  mem_bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .busy   ((state_q == ST_IF_BUSY) || (state_q == ST_MEM_BUSY)),
    .timeout(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    // Ready pulses are only ever set on the BUSY->DONE transition.
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    bus_err_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_sel_d   = mem_sel;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          state_d     = ST_MEM_BUSY;
        end else if (if_req) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = '1;
          bus_addr_d  = if_addr;
          state_d     = ST_IF_BUSY;
        end
      end

      // An ack in the timeout cycle takes precedence over the abort.
      ST_IF_BUSY: begin
        if (bus_ack) begin
          if_rdata_d = bus_rdata;
          if_ready_d = 1'b1;
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
          state_d    = ST_IF_DONE;
        end else if (timeout_hit) begin
          if_rdata_d = '0;
          if_ready_d = 1'b1;
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
          bus_err_d  = 1'b1;
`endif
          state_d    = ST_IF_DONE;
        end
      end

      ST_MEM_BUSY: begin
        if (bus_ack) begin
          mem_rdata_d = bus_rdata;
          mem_ready_d = 1'b1;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          state_d     = ST_MEM_DONE;
        end else if (timeout_hit) begin
          mem_rdata_d = '0;
          mem_ready_d = 1'b1;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
          bus_err_d   = 1'b1;
`endif
          state_d     = ST_MEM_DONE;
        end
      end

      // DONE never grants, so a requester still holding req is not re-served.
      ST_IF_DONE,
      ST_MEM_DONE: state_d = ST_IDLE;

      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
        bus_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_sel   = bus_sel_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Stall requests are combinational so the pipeline freezes in the same
  // cycle a request is raised; forced low while reset is asserted.
  logic rst_active;
  assign rst_active    = RESET_ENABLE & reset;
  assign stall_req_if  = STALL_ENABLE & if_req  & ~if_ready_q  & ~rst_active;
  assign stall_req_mem = STALL_ENABLE & mem_req & ~mem_ready_q & ~rst_active;

endmodule : mem_bus_arbiter
